// File: rtl/ln_row_packer.sv
// ln_row_packer
//   Collects a token row of N_ELEM signed DATA_W-bit elements arriving as a
//   ready/valid beat stream (LANES elements per beat, delimited by i_s_last).
//   It emits each complete row as one flat vector with a single valid pulse
//   for the LayerNorm input. Short and long rows raise sticky error flags.
//
// Ports
//   i_clk        clock, posedge
//   i_rst        asynchronous active-high reset
//   i_en         global enable; every register advances only while high
//   i_s_valid    input beat valid
//   o_s_ready    input beat ready (i_en & ~i_rst)
//   i_s_data     beat payload, lane j at [DATA_W*j +: DATA_W]
//   i_s_last     last beat of the row
//   i_err_clr    clears the sticky error flags (set wins over clear)
//   o_valid      row valid pulse, held while i_en is low
//   o_data_flat  packed row, element e at [DATA_W*e +: DATA_W]
//   o_err_short  sticky: row ended before N_ELEM elements
//   o_err_long   sticky: row ran past N_ELEM elements
//   o_row_count  rows emitted, wraps at 2^16
module ln_row_packer #(
  parameter int DATA_W    = 16,
  parameter int N_ELEM    = 64,
  parameter int LANES     = 4,
  parameter int PAD_SHORT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  input  logic [LANES*DATA_W-1:0]    i_s_data,
  input  logic                       i_s_last,
  input  logic                       i_err_clr,
  output logic                       o_valid,
  output logic [N_ELEM*DATA_W-1:0]   o_data_flat,
  output logic                       o_err_short,
  output logic                       o_err_long,
  output logic [15:0]                o_row_count
);

  localparam int BEATS  = N_ELEM / LANES;
  localparam int BEAT_W = LANES * DATA_W;
  localparam int ROW_W  = N_ELEM * DATA_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_FILL, S_DISCARD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BEAT_W-1:0]  row_buf [BEATS];
  logic [ROW_W-1:0]   next_row;
  logic [31:0]        cnt_w;

  logic accept, fill_acc, at_end, full_row, short_row, set_long, emit;

  assign o_s_ready = i_en & ~i_rst;
  assign accept    = i_s_valid & o_s_ready;
  assign fill_acc  = accept & (state == S_FILL);
  assign at_end    = (cnt == CNT_W'(BEATS - 1));
  assign full_row  = fill_acc & at_end;
  assign short_row = fill_acc & i_s_last & ~at_end;
  assign set_long  = full_row & ~i_s_last;
  assign emit      = full_row | (short_row & (PAD_SHORT != 0));
  assign cnt_w     = 32'(cnt);

  // The completing beat goes straight from i_s_data into the emitted row, so
  // the row is available one cycle after the last accept. Beat slots beyond
  // the current one may hold stale data from an earlier row. They are zeroed
  // here, which also provides the padding for short rows.
  always_comb begin
    next_row = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (k < cnt_w) begin
        next_row[k*BEAT_W +: BEAT_W] = row_buf[k];
      end else if (k == cnt_w) begin
        next_row[k*BEAT_W +: BEAT_W] = i_s_data;
      end
    end
  end

  // Only slots below cnt are ever read back, so the buffer needs no reset.
  always_ff @(posedge i_clk) begin
    if (fill_acc) begin
      row_buf[cnt] <= i_s_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_FILL;
      cnt         <= '0;
      o_valid     <= 1'b0;
      o_data_flat <= '0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_row_count <= '0;
    end else if (i_en) begin
      o_valid     <= emit;
      o_err_short <= short_row | (o_err_short & ~i_err_clr);
      o_err_long  <= set_long  | (o_err_long  & ~i_err_clr);
      if (emit) begin
        o_data_flat <= next_row;
        o_row_count <= o_row_count + 16'd1;
      end
      case (state)
        S_FILL: begin
          if (accept) begin
            if (at_end || i_s_last) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            if (set_long) begin
              state <= S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (accept && i_s_last) begin
            state <= S_FILL;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ln_row_packer.sv
// Testbench for ln_row_packer. It runs two instances on shared stimulus, one
// with PAD_SHORT=1 and one with PAD_SHORT=0, and checks both against an
// element-queue reference model.
module tb_ln_row_packer;

  localparam int DATA_W = 16;
  localparam int N_ELEM = 64;
  localparam int LANES  = 4;
  localparam int BEATS  = N_ELEM / LANES;
  localparam int BEAT_W = LANES * DATA_W;
  localparam int ROW_W  = N_ELEM * DATA_W;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_en = 1'b0;
  logic              i_s_valid = 1'b0;
  logic              i_s_last = 1'b0;
  logic              i_err_clr = 1'b0;
  logic [BEAT_W-1:0] i_s_data = '0;

  logic [1:0]        s_ready, valid, err_short, err_long;
  logic [ROW_W-1:0]  data_flat [2];
  logic [15:0]       row_count [2];

  ln_row_packer #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .LANES(LANES), .PAD_SHORT(1)) u_pad (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_s_valid(i_s_valid),
    .o_s_ready(s_ready[0]), .i_s_data(i_s_data), .i_s_last(i_s_last),
    .i_err_clr(i_err_clr), .o_valid(valid[0]), .o_data_flat(data_flat[0]),
    .o_err_short(err_short[0]), .o_err_long(err_long[0]), .o_row_count(row_count[0])
  );

  ln_row_packer #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .LANES(LANES), .PAD_SHORT(0)) u_drop (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_s_valid(i_s_valid),
    .o_s_ready(s_ready[1]), .i_s_data(i_s_data), .i_s_last(i_s_last),
    .i_err_clr(i_err_clr), .o_valid(valid[1]), .o_data_flat(data_flat[1]),
    .o_err_short(err_short[1]), .o_err_long(err_long[1]), .o_row_count(row_count[1])
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: elements of the current row, discard flag, sticky errors,
  // and per-instance output expectations (index 0 pads, index 1 drops).
  logic [DATA_W-1:0] cur [$];
  bit                discard;
  bit                m_short, m_long;
  bit                m_valid [2];
  logic [ROW_W-1:0]  m_data  [2];
  logic [15:0]       m_cnt   [2];

  task automatic model_reset();
    cur.delete();
    discard = 0;
    m_short = 0;
    m_long  = 0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
      m_cnt[i]   = '0;
    end
  endtask

  task automatic model_edge();
    bit emit_full, emit_short, s_set, l_set, emit;
    logic [ROW_W-1:0] row;
    if (!i_en) return;
    emit_full = 0; emit_short = 0; s_set = 0; l_set = 0;
    row = '0;
    if (i_s_valid) begin
      if (discard) begin
        if (i_s_last) discard = 0;
      end else begin
        for (int j = 0; j < LANES; j++) cur.push_back(i_s_data[j*DATA_W +: DATA_W]);
        if (cur.size() == N_ELEM || i_s_last) begin
          for (int e = 0; e < cur.size(); e++) row[e*DATA_W +: DATA_W] = cur[e];
          if (cur.size() == N_ELEM) begin
            emit_full = 1;
            if (!i_s_last) begin
              l_set   = 1;
              discard = 1;
            end
          end else begin
            s_set      = 1;
            emit_short = 1;
          end
          cur.delete();
        end
      end
    end
    m_short = s_set || (m_short && !i_err_clr);
    m_long  = l_set || (m_long && !i_err_clr);
    for (int i = 0; i < 2; i++) begin
      emit = emit_full || (emit_short && i == 0);
      m_valid[i] = emit;
      if (emit) begin
        m_data[i] = row;
        m_cnt[i]  = m_cnt[i] + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid%0d", i), valid[i], m_valid[i]);
      check($sformatf("err_short%0d", i), err_short[i], m_short);
      check($sformatf("err_long%0d", i), err_long[i], m_long);
      check($sformatf("row_count%0d", i), row_count[i], m_cnt[i]);
      for (int q = 0; q < ROW_W / 256; q++) begin
        check($sformatf("data%0d_q%0d", i, q), data_flat[i][q*256 +: 256], m_data[i][q*256 +: 256]);
      end
    end
  endtask

  // Entered shortly after a posedge with inputs already driven.
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready%0d", i), s_ready[i], (i_en && !i_rst));
    end
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready_rst%0d", i), s_ready[i], 1'b0);
    end
    compare_all();
    #1;
    i_rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit en, input bit clr);
    for (int k = 0; k < n; k++) begin
      i_en = en; i_s_valid = 0; i_s_last = 0; i_err_clr = clr;
      cycle();
    end
    i_err_clr = 0;
  endtask

  // One accepted beat, optionally preceded by random non-accepting cycles.
  task automatic beat(input logic [BEAT_W-1:0] d, input bit last, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      if ($urandom_range(1, 0) == 1) begin
        i_en = 0; i_s_valid = 1;
      end else begin
        i_en = 1; i_s_valid = 0;
      end
      i_s_data  = {$urandom, $urandom};
      i_s_last  = 1'($urandom_range(1, 0));
      i_err_clr = 0;
      cycle();
    end
    i_en = 1; i_s_valid = 1; i_s_data = d; i_s_last = last; i_err_clr = 0;
    cycle();
    i_s_valid = 0;
    i_s_last  = 0;
  endtask

  // mode 0: random data, 1: element e holds e, 2: all 0x7FFF
  task automatic send_row(input int nbeats, input int last_at, input int mode, input int max_gap);
    logic [BEAT_W-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < LANES; j++) begin
        case (mode)
          1:       d[j*DATA_W +: DATA_W] = DATA_W'(b * LANES + j);
          2:       d[j*DATA_W +: DATA_W] = 16'h7FFF;
          default: d[j*DATA_W +: DATA_W] = DATA_W'($urandom);
        endcase
      end
      beat(d, b == last_at, max_gap);
    end
  endtask

  initial begin
    int nb;
    #2;
    do_reset();
    @(posedge i_clk);
    #1;
    idle(2, 1, 0);

    // Ascending full row, then three back-to-back random rows.
    send_row(BEATS, BEATS - 1, 1, 0);
    idle(1, 1, 0);
    for (int r = 0; r < 3; r++) send_row(BEATS, BEATS - 1, 0, 0);
    idle(1, 1, 0);

    // Short row: last on beat 5.
    send_row(6, 5, 2, 0);
    idle(2, 1, 0);

    // Long row: 20 beats, then a good row.
    send_row(20, 19, 0, 0);
    send_row(BEATS, BEATS - 1, 0, 0);

    // Enable drops right after the completing beat.
    send_row(BEATS, BEATS - 1, 0, 0);
    i_s_valid = 1;
    idle(3, 0, 0);
    idle(2, 1, 0);

    // Clear both sticky flags, then reset mid-row and send a full row.
    idle(1, 1, 1);
    send_row(7, 100, 0, 0);
    do_reset();
    send_row(BEATS, BEATS - 1, 0, 0);
    idle(2, 1, 0);

    // Randomised rows with gaps, enable drops, clears and mid-row resets.
    for (int r = 0; r < 40; r++) begin
      nb = int'($urandom_range(20, 1));
      if ($urandom_range(9, 0) == 0) begin
        send_row(nb, 100, 0, 2);
        do_reset();
      end else begin
        send_row(nb, nb - 1, 0, 2);
      end
      if ($urandom_range(3, 0) == 0) idle(1, 1, 1);
    end
    idle(2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
